si_reg_bridge: RTL

SI_REG_BRIDGE -- requirements
Module: si_reg_bridge

---
 rtl/si_reg_bridge_pkg.sv | 29 ++
 rtl/si_timeout_cnt.sv | 37 +++
 rtl/si_reg_bridge.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/si_reg_bridge_pkg.sv
// Shared definitions for the FT245 simple-interface register bridge:
// FSM encoding, header field layout and register-map constants.
package si_reg_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWdata = 2'd1,
        StTx    = 2'd2
    } state_e;

    localparam int unsigned W_BIT       = 7;
    localparam int unsigned ADDR_LSB    = 0;
    localparam int unsigned ADDR_W      = 3;
    localparam int unsigned NUM_RW_REGS = 7;
    localparam int unsigned REG_W       = 8;
    localparam int unsigned CFG_W       = NUM_RW_REGS * REG_W;

    localparam logic [ADDR_W-1:0] ID_ADDR = 3'd7;

    // Bits between the W flag and the address field must be zero.
    function automatic logic hdr_valid(input logic [7:0] hdr);
        return hdr[W_BIT-1:ADDR_LSB+ADDR_W] == '0;
    endfunction

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
        return hdr[ADDR_LSB +: ADDR_W];
    endfunction

endpackage

// File: rtl/si_timeout_cnt.sv
// Inter-byte timeout counter: cleared on request, counts while enabled and
// flags expiry once it reaches TIMEOUT_CYCLES-1.
module si_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired_o = en_i && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/si_reg_bridge.sv
// Byte-oriented register bridge on an FT245 simple interface: one header byte
// selects read/write and address; writes carry one data byte, reads return one.
module si_reg_bridge
    import si_reg_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  ID_VALUE       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_si,
    input  logic        rx_rdy_si,
    output logic        rx_ack_si,
    output logic [7:0]  tx_data_si,
    output logic        tx_rdy_si,
    input  logic        tx_ack_si,
    output logic [55:0] cfg_regs,
    output logic        wr_stb,
    output logic [2:0]  wr_addr,
    output logic [7:0]  err_cnt
);

    // Reset asserts asynchronously but releases two clocks later.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    state_e            state_q, state_d;
    logic              rx_ack_q, rx_ack_d;
    logic [7:0]        byte_q, byte_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              tx_rdy_q, tx_rdy_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [CFG_W-1:0]  cfg_q, cfg_d;
    logic              wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        err_q, err_d;

    logic              err_inc;
    logic [7:0]        rd_byte;
    logic              tmo_clr, tmo_en, tmo_expired;

    always_comb begin
        rd_byte = ID_VALUE;
        for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (hdr_addr(byte_q) == ADDR_W'(i)) begin
                rd_byte = cfg_q[i*REG_W +: REG_W];
            end
        end
    end

    // A byte is captured when acked and decoded during the following holdoff
    // cycle, so rx_rdy_si is never looked at while the ack is still visible.
    always_comb begin
        state_d   = state_q;
        rx_ack_d  = 1'b0;
        byte_d    = byte_q;
        addr_d    = addr_q;
        tx_rdy_d  = tx_rdy_q;
        tx_data_d = tx_data_q;
        cfg_d     = cfg_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        err_d     = err_q;
        err_inc   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_ack_q) begin
                    if (!hdr_valid(byte_q)) begin
                        err_inc = 1'b1;
                    end else begin
                        addr_d = hdr_addr(byte_q);
                        if (byte_q[W_BIT]) begin
                            state_d = StWdata;
                        end else begin
                            state_d   = StTx;
                            tx_rdy_d  = 1'b1;
                            tx_data_d = rd_byte;
                        end
                    end
                end else if (rx_rdy_si) begin
                    rx_ack_d = 1'b1;
                    byte_d   = rx_data_si;
                end
            end
            StWdata: begin
                if (rx_ack_q) begin
                    state_d = StIdle;
                    if (addr_q != ID_ADDR) begin
                        for (int i = 0; i < NUM_RW_REGS; i++) begin
                            if (addr_q == ADDR_W'(i)) begin
                                cfg_d[i*REG_W +: REG_W] = byte_q;
                            end
                        end
                        wr_stb_d  = 1'b1;
                        wr_addr_d = addr_q;
                    end
                end else if (rx_rdy_si) begin
                    rx_ack_d = 1'b1;
                    byte_d   = rx_data_si;
                end else if (tmo_expired) begin
                    state_d = StIdle;
                    err_inc = 1'b1;
                end
            end
            StTx: begin
                if (tx_ack_si) begin
                    tx_rdy_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d  = StIdle;
                tx_rdy_d = 1'b0;
            end
        endcase

        if (err_inc && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    assign tmo_clr = (state_d == StWdata) && (state_q != StWdata);
    assign tmo_en  = (state_q == StWdata);

    si_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .expired_o(tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rx_ack_q  <= 1'b0;
            byte_q    <= 8'h00;
            addr_q    <= '0;
            tx_rdy_q  <= 1'b0;
            tx_data_q <= 8'h00;
            cfg_q     <= '0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            err_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            rx_ack_q  <= rx_ack_d;
            byte_q    <= byte_d;
            addr_q    <= addr_d;
            tx_rdy_q  <= tx_rdy_d;
            tx_data_q <= tx_data_d;
            cfg_q     <= cfg_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            err_q     <= err_d;
        end
    end

    assign rx_ack_si  = rx_ack_q;
    assign tx_rdy_si  = tx_rdy_q;
    assign tx_data_si = tx_data_q;
    assign cfg_regs   = cfg_q;
    assign wr_stb     = wr_stb_q;
    assign wr_addr    = wr_addr_q;
    assign err_cnt    = err_q;

endmodule
